// File: rtl/rfsoc_config.sv
// rtl/rfsoc_config.sv - shared constants and state encoding for the ADC capture path
package rfsoc_config;

  localparam int DATA_W    = 256;
  localparam int ARM_BIT   = 15;
  localparam int ABORT_BIT = 14;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_READOUT = 2'd3
  } state_e;

endpackage

// File: rtl/capture_ram.sv
// rtl/capture_ram.sv - simple dual-port capture buffer, synchronous write, registered read
module capture_ram
  import rfsoc_config::*;
#(
  parameter int addr_w = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [addr_w-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [addr_w-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [2**addr_w];
  logic [DATA_W-1:0] rd_data_q;

  // No reset: contents and read register are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/adc_capture.sv
// rtl/adc_capture.sv - triggered ADC beat capture with AXI-Stream readout to the PS
module adc_capture
  import rfsoc_config::*;
#(
  parameter int mem_width = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       gpio_ctrl,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  input  logic              trigger_in,
  input  logic              select_in,
  output logic [1:0]        status
);

  localparam int PW = mem_width + 1;

  state_e                state_q, state_d;
  logic                  arm_q, arm_d;
  logic                  ready_q, ready_d;
  logic [mem_width-1:0]  len_q, len_d;
  logic [mem_width-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  pend_q, pend_d;
  logic                  pend_last_q, pend_last_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [DATA_W-1:0]     out_data_q, out_data_d;
  logic                  skid_valid_q, skid_valid_d;
  logic                  skid_last_q, skid_last_d;
  logic [DATA_W-1:0]     skid_data_q, skid_data_d;

  logic                  wr_en, rd_en, pop;
  logic                  arm_edge, trig, abort;
  logic [DATA_W-1:0]     rd_data;
  logic                  gpio_unused;

  // Edge detection is held off for the first cycle out of reset so a level
  // already high at reset release is not mistaken for a fresh arm.
  assign arm_edge    = ready_q & gpio_ctrl[ARM_BIT] & ~arm_q;
  assign trig        = trigger_in & select_in;
  assign abort       = gpio_ctrl[ABORT_BIT];
  assign pop         = out_valid_q & m_axis_tready;
  assign gpio_unused = ^gpio_ctrl;

  always_comb begin
    state_d      = state_q;
    arm_d        = gpio_ctrl[ARM_BIT];
    ready_d      = 1'b1;
    len_d        = len_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    pend_d       = 1'b0;
    pend_last_d  = 1'b0;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_last_d  = skid_last_q;
    skid_data_d  = skid_data_q;
    wr_en        = 1'b0;
    rd_en        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        if (arm_edge) begin
          len_d   = gpio_ctrl[mem_width-1:0];
          state_d = ST_ARMED;
        end
      end

      ST_ARMED: begin
        if (abort) state_d = ST_IDLE;
        else if (trig) state_d = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        if (abort) begin
          state_d  = ST_IDLE;
          wr_ptr_d = '0;
        end else if (s_axis_tvalid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + mem_width'(1);
          if (wr_ptr_q == len_q) begin
            state_d  = ST_READOUT;
            wr_ptr_d = '0;
          end
        end
      end

      ST_READOUT: begin
        // Output register is refilled from the skid first, then from the RAM;
        // a RAM word that arrives while the output is stalled parks in the skid.
        if (!out_valid_q || pop) begin
          if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            out_last_d   = skid_last_q;
            skid_valid_d = pend_q;
            skid_data_d  = rd_data;
            skid_last_d  = pend_last_q;
          end else begin
            out_valid_d  = pend_q;
            out_data_d   = rd_data;
            out_last_d   = pend_last_q;
          end
        end else if (pend_q) begin
          skid_valid_d = 1'b1;
          skid_data_d  = rd_data;
          skid_last_d  = pend_last_q;
        end

        // Issue a read only if the word landing next cycle is guaranteed a slot.
        rd_en       = (rd_ptr_q <= PW'(len_q)) && !(out_valid_d && skid_valid_d);
        pend_d      = rd_en;
        pend_last_d = rd_en && (rd_ptr_q == PW'(len_q));
        if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);

        if (pop && out_last_q) begin
          state_d      = ST_IDLE;
          out_valid_d  = 1'b0;
          out_last_d   = 1'b0;
          skid_valid_d = 1'b0;
          pend_d       = 1'b0;
          pend_last_d  = 1'b0;
          rd_en        = 1'b0;
          rd_ptr_d     = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      arm_q        <= 1'b0;
      ready_q      <= 1'b0;
      len_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pend_q       <= 1'b0;
      pend_last_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_last_q  <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      arm_q        <= arm_d;
      ready_q      <= ready_d;
      len_q        <= len_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pend_q       <= pend_d;
      pend_last_q  <= pend_last_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_last_q  <= skid_last_d;
      skid_data_q  <= skid_data_d;
    end
  end

  capture_ram #(
    .addr_w(mem_width)
  ) u_capture_ram (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wr_ptr_q),
    .wr_data(s_axis_tdata),
    .rd_en  (rd_en),
    .rd_addr(rd_ptr_q[mem_width-1:0]),
    .rd_data(rd_data)
  );

  assign s_axis_tready = ready_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tlast  = out_last_q;
  assign status        = state_q;

endmodule

// File: tb/tb_adc_capture.sv
// tb/tb_adc_capture.sv - randomized self-checking bench for adc_capture
module tb_adc_capture;

  localparam int MW = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [15:0]  gpio_ctrl = '0;
  logic [255:0] s_axis_tdata = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic [255:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b0;
  logic         m_axis_tlast;
  logic         trigger_in = 1'b0;
  logic         select_in = 1'b0;
  logic [1:0]   status;

  adc_capture #(.mem_width(MW)) dut (
    .clk          (clk),
    .rst          (rst),
    .gpio_ctrl    (gpio_ctrl),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .trigger_in   (trigger_in),
    .select_in    (select_in),
    .status       (status)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_fail = 0;

  logic [255:0] exp_q[$];
  logic [255:0] got_q[$];
  bit           got_last[$];
  int           got_cyc[$];
  int           first_valid_cyc = -1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    exp_q.delete();
    got_q.delete();
    got_last.delete();
    got_cyc.delete();
    first_valid_cyc = -1;
  endtask

  // Output monitor: records every handshake and enforces the hold rule while stalled.
  initial begin
    bit           prev_stall;
    logic [255:0] prev_data;
    logic         prev_last;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", m_axis_tvalid, 1'b1);
          check("stall_data", m_axis_tdata, prev_data);
          check("stall_last", m_axis_tlast, prev_last);
        end
        if (m_axis_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (m_axis_tvalid && m_axis_tready) begin
          got_q.push_back(m_axis_tdata);
          got_last.push_back(m_axis_tlast);
          got_cyc.push_back(cyc);
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
      end
    end
  end

  // Arm edge with length len; afterwards the length field is scrambled to show it was latched.
  task automatic arm(input int len, input bit trig_same);
    gpio_ctrl = 16'(len);
    tick();
    gpio_ctrl[15] = 1'b1;
    trigger_in    = trig_same;
    select_in     = trig_same;
    tick();
    gpio_ctrl  = {2'b00, 14'($urandom)};
    trigger_in = 1'b0;
    select_in  = 1'b0;
  endtask

  // Reference: the first len+1 valid ADC beats after the trigger cycle come out in order,
  // last one flagged, stall hold honoured, then the block is idle.
  task automatic do_capture(input int len, input int vprob, input int rprob, input bit count_mode);
    int           wr_n;
    int           last_wr;
    int           guard;
    int           adc_n;
    bit           v;
    logic [255:0] d;
    wr_n    = 0;
    last_wr = 0;
    guard   = 0;
    adc_n   = 0;
    clear_obs();
    arm(len, 1'b0);
    trigger_in    = 1'b1;
    select_in     = 1'b1;
    s_axis_tvalid = count_mode ? 1'b0 : 1'($urandom_range(1));
    s_axis_tdata  = rand256();
    tick();
    trigger_in = 1'b0;
    select_in  = 1'b0;
    while (got_q.size() < len + 1 && guard < 400) begin
      v = count_mode ? 1'b1 : ($urandom_range(99) < vprob);
      d = count_mode ? 256'(adc_n) : rand256();
      adc_n++;
      s_axis_tvalid = v;
      s_axis_tdata  = d;
      m_axis_tready = ($urandom_range(99) < rprob);
      if (v && wr_n <= len) begin
        exp_q.push_back(d);
        wr_n++;
        last_wr = cyc + 1;
      end
      tick();
      guard++;
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    check("beats_out", got_q.size(), len + 1);
    check("beats_captured", exp_q.size(), len + 1);
    check("post_last_tvalid", m_axis_tvalid, 1'b0);
    check("post_last_status", status, 2'd0);
    if (got_q.size() == len + 1 && exp_q.size() == len + 1) begin
      for (int i = 0; i <= len; i++) begin
        check($sformatf("data[%0d]", i), got_q[i], exp_q[i]);
        check($sformatf("tlast[%0d]", i), got_last[i], i == len);
        if (count_mode) check($sformatf("count[%0d]", i), got_q[i], 256'(i));
      end
      check("first_latency", (first_valid_cyc - last_wr) inside {[1:2]}, 1'b1);
      if (rprob == 100) check("back_to_back", got_cyc[len] - got_cyc[0], len);
    end
  endtask

  initial begin
    int g;

    #1;
    check("rst_tready", s_axis_tready, 1'b0);
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tlast", m_axis_tlast, 1'b0);
    check("rst_tdata", m_axis_tdata, '0);
    check("rst_status", status, 2'd0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    tick();
    check("run_tready", s_axis_tready, 1'b1);
    check("run_status", status, 2'd0);

    // Basic capture: counting ADC, L=3, continuous tready.
    do_capture(3, 100, 100, 1'b1);

    // Trigger coincident with the arm edge is ignored; trigger without select never fires.
    clear_obs();
    arm(2, 1'b1);
    tick();
    check("trig_with_arm", status, 2'd1);
    trigger_in    = 1'b1;
    select_in     = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = rand256();
    repeat (6) tick();
    check("nosel_status", status, 2'd1);
    check("nosel_beats", got_q.size(), 0);
    select_in     = 1'b1;
    gpio_ctrl[14] = 1'b1;
    tick();
    check("abort_over_trig", status, 2'd0);
    gpio_ctrl     = '0;
    trigger_in    = 1'b0;
    select_in     = 1'b0;
    s_axis_tvalid = 1'b0;
    tick();

    // Gappy ADC, then random PS backpressure.
    do_capture(7, 50, 100, 1'b0);
    do_capture(4, 90, 50, 1'b0);

    // Abort mid-capture after two beats, then a clean re-arm.
    clear_obs();
    arm(5, 1'b0);
    trigger_in = 1'b1;
    select_in  = 1'b1;
    tick();
    trigger_in    = 1'b0;
    select_in     = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = rand256();
    tick();
    tick();
    check("capture_status", status, 2'd2);
    gpio_ctrl[14] = 1'b1;
    tick();
    check("abort_status", status, 2'd0);
    check("abort_tvalid", m_axis_tvalid, 1'b0);
    gpio_ctrl[14] = 1'b0;
    m_axis_tready = 1'b1;
    repeat (5) tick();
    check("abort_no_beats", got_q.size(), 0);
    s_axis_tvalid = 1'b0;
    do_capture(3, 80, 100, 1'b0);

    // Reset in the middle of a stalled readout with arm held high across release.
    clear_obs();
    arm(6, 1'b0);
    trigger_in = 1'b1;
    select_in  = 1'b1;
    tick();
    trigger_in    = 1'b0;
    select_in     = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = rand256();
    m_axis_tready = 1'b0;
    gpio_ctrl[15] = 1'b1;
    g = 0;
    while (!m_axis_tvalid && g < 30) begin
      s_axis_tdata = rand256();
      tick();
      g++;
    end
    check("ro_valid_before_rst", m_axis_tvalid, 1'b1);
    check("ro_status_before_rst", status, 2'd3);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_tvalid", m_axis_tvalid, 1'b0);
    check("mid_rst_status", status, 2'd0);
    check("mid_rst_tlast", m_axis_tlast, 1'b0);
    check("mid_rst_tdata", m_axis_tdata, '0);
    check("mid_rst_tready", s_axis_tready, 1'b0);
    tick();
    tick();
    rst           = 1'b1;
    trigger_in    = 1'b1;
    select_in     = 1'b1;
    s_axis_tvalid = 1'b0;
    repeat (4) tick();
    check("held_arm_status", status, 2'd0);
    check("held_arm_tready", s_axis_tready, 1'b1);
    gpio_ctrl  = '0;
    trigger_in = 1'b0;
    select_in  = 1'b0;
    tick();

    // Single-beat capture, then a few fully random ones.
    do_capture(0, 100, 100, 1'b0);
    for (int k = 0; k < 3; k++) do_capture($urandom_range(15), 70, 60, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_capture.md
ADC_CAPTURE -- requirements
Module: adc_capture

Interface
REQ-001 SHALL have parameter mem_width, default 10, log2 of capture buffer depth in 256-bit words (legal 4..14).
REQ-002 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port gpio_ctrl  input  16  control word: [15] arm, [14] abort, [mem_width-1:0] capture length minus one (L).
REQ-005 SHALL have port s_axis_tdata  input  256  ADC sample beat from the RFSoC IP.
REQ-006 SHALL have port s_axis_tvalid  input  1  ADC beat valid.
REQ-007 SHALL have port s_axis_tready  output  1  ADC ready.
REQ-008 SHALL have port m_axis_tdata  output  256  captured beat to PS.
REQ-009 SHALL have port m_axis_tvalid  output  1  PS stream valid.
REQ-010 SHALL have port m_axis_tready  input  1  PS stream ready.
REQ-011 SHALL have port m_axis_tlast  output  1  marks final beat of a capture.
REQ-012 SHALL have port trigger_in  input  1  shared system trigger.
REQ-013 SHALL have port select_in  input  1  channel select; trigger only counts when high.
REQ-014 SHALL have port status  output  2  current FSM state code.

Function
REQ-015 SHALL hold s_axis_tready at 1 when out of reset; ADC is never backpressured; beats outside CAPTURE are discarded.
REQ-016 SHALL implement FSM IDLE(0) -> ARMED(1) -> CAPTURE(2) -> READOUT(3) -> IDLE.
REQ-017 SHALL leave IDLE for ARMED on a 0->1 edge of gpio_ctrl[15] (registered edge detect); a level held high does not re-arm.
REQ-018 SHALL latch L from gpio_ctrl at the arm edge; later gpio_ctrl changes do not affect the capture in progress.
REQ-019 SHALL leave ARMED for CAPTURE in the cycle after a cycle where trigger_in && select_in is high; trigger in the same cycle as arm edge is ignored.
REQ-020 SHALL, in CAPTURE, write each beat with s_axis_tvalid high to buffer address wr_ptr (starting 0), increment wr_ptr, and enter READOUT after the (L+1)th write.
REQ-021 SHALL ignore trigger_in outside ARMED (no retrigger during CAPTURE/READOUT).
REQ-022 SHALL, in READOUT, present words 0..L in order on m_axis with AXIS rules: tdata/tlast stable while tvalid high and tready low; tvalid never drops without a handshake.
REQ-023 SHALL assert m_axis_tlast with word L only; L=0 yields a single beat with tlast.
REQ-024 SHALL return to IDLE the cycle after the tlast handshake, with m_axis_tvalid low that cycle.
REQ-025 SHALL cover the 1-cycle RAM read latency with a prefetch/skid register so that continuous tready yields one beat per cycle after a first-beat latency of at most 2 cycles from READOUT entry.
REQ-026 SHALL, on gpio_ctrl[14] high in ARMED or CAPTURE, return to IDLE next cycle discarding partial data; abort is ignored in READOUT; abort has priority over simultaneous trigger.
REQ-027 SHALL drive status with the current state code, registered.

Reset
REQ-028 SHALL on rst low asynchronously force: state IDLE, status 0, m_axis_tvalid 0, m_axis_tlast 0, m_axis_tdata 0, s_axis_tready 0, pointers 0, arm-edge register 0.
REQ-029 SHALL abandon any capture or readout when reset is asserted mid-operation; buffer contents are undefined after reset.

Structure
REQ-030 SHALL place the state enum, gpio_ctrl bit positions (ARM_BIT=15, ABORT_BIT=14) and the 256-bit data width constant in package rfsoc_config.
REQ-031 SHALL instantiate one sub-module capture_ram: simple dual-port, 2**mem_width x 256, synchronous write, 1-cycle registered read, no reset.

Verification
REQ-032 SHALL test: arm, L=3, trigger with select_in=1, ADC counts 0..9 continuous, tready=1 -> m_axis emits 0,1,2,3 back-to-back, tlast on 3, status ends 0.
REQ-033 SHALL test: trigger with select_in=0 in ARMED -> stays ARMED (status 1), no output beats.
REQ-034 SHALL test: L=7, s_axis_tvalid toggling 50% -> exactly 8 valid beats captured in order, gaps not stored.
REQ-035 SHALL test: L=4, m_axis_tready random -> 5 beats, no data/tlast change while stalled, no duplicates or drops.
REQ-036 SHALL test: abort during CAPTURE after 2 beats -> IDLE next cycle, m_axis_tvalid stays 0; re-arm and capture completes normally.
REQ-037 SHALL test: rst low mid-READOUT -> m_axis_tvalid 0 within same cycle, status 0; arm held high through reset release does not arm.
